mux2_sel_reg: RTL and testbench
===============================

// Module: mux2_sel_reg
// PURPOSE
//  Two-input selector: routes A_in or B_in to Y under control of Select, combinationally.
//  Also provides a registered copy of Y and a counter of Select transitions.
//  Used as a leaf data-path element wherever one of two sources must be selected.
// PARAMETERS
//  WIDTH      1  data width of A_in, B_in, Y, Y_q (WIDTH >= 1)
//  SEL_CNT_W  8  width of the Select-transition counter sel_cnt (>= 1)
// PORTS
//  clk      in   1          rising-edge clock, sole clock domain
//  rst      in   1          asynchronous, active-high reset
//  Select   in   1          0 -> A_in, 1 -> B_in
//  A_in     in   WIDTH      data input 0
//  B_in     in   WIDTH      data input 1
//  Y        out  WIDTH      combinational mux output
//  Y_q      out  WIDTH      registered Y, 1-cycle latency
//  sel_cnt  out  SEL_CNT_W  number of Select edges seen (registered)
//  Y_par    out  1          even parity of Y_q (only with MUX2_PARITY_EN)
// BEHAVIOUR
//  - Y = Select ? B_in : A_in; purely combinational, zero latency, no dependence on clk/rst.
//  - Select X/Z: Y is don't-care; no X-pessimism handling is required.
//  - Y_q <= Y on every rising clk; reset value all-zeros.
//  - sel_prev <= Select each clk; reset value 0.
//  - sel_cnt increments by 1 on each clk where Select != sel_prev; wraps from all-ones to 0.
//    Reset value 0. The first edge after reset is counted relative to sel_prev=0.
//  - Reset asserted mid-operation: Y_q, sel_prev, sel_cnt (and Y_par) clear immediately,
//    asynchronously. Y keeps following its inputs while rst is high.
//  - Reset deassertion takes effect at the first rising clk after release.
//  - No handshake, no stall, no enable.
// CONFIGURATION
//  MUX2_PARITY_EN defined: Y_par = ^Y_q, registered together with Y_q; reset value 0.
//  MUX2_PARITY_EN undefined: Y_par port and its logic are absent; all else is identical.
// STRUCTURE
//  Package mux2_pkg: SEL_A=1'b0, SEL_B=1'b1 constants; default WIDTH and SEL_CNT_W.
//  Sub-module mux2_comb: the combinational WIDTH-bit 2:1 selector.
//  The top level adds the registers, the edge counter and the optional parity.
// TESTING
//  1. Exhaustive sweep, WIDTH=1: Select/A_in/B_in over all 8 combinations, 5 ns apart,
//     repeated 12 times. Required: Select=0 gives Y=A_in; Select=1 gives Y=B_in.
//  2. Latency, WIDTH=8: A=8'h5A, B=8'hA5, Select toggles each cycle.
//     Required: Y_q equals the prior cycle's Y (5A, A5, 5A, ...).
//  3. Counter: 10 Select toggles -> sel_cnt=10. With SEL_CNT_W=2 and 5 toggles -> sel_cnt=1 (wrap).
//  4. Async reset: assert rst between clk edges with Y_q=8'hA5 and sel_cnt=3.
//     Required: both read 0 before the next edge; Y still equals the selected input.
//  5. Parity build (MUX2_PARITY_EN defined): Y_q=8'h07 -> Y_par=1; Y_q=8'h03 -> Y_par=0.
//  6. Hold: Select held at 1 for 20 cycles while B_in varies. Required: sel_cnt unchanged; Y tracks B_in.

Source files
------------

// File: rtl/mux2_pkg.sv
// Shared constants for the mux2_sel_reg slice: select encodings and default sizes.
package mux2_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEF_WIDTH     = 1;
    localparam int DEF_SEL_CNT_W = 8;

endpackage : mux2_pkg

// File: rtl/mux2_comb.sv
// Purely combinational WIDTH-bit 2:1 selector; no clock, no reset.
module mux2_comb
    import mux2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        if (sel_i == SEL_B) begin
            y_o = b_i;
        end
    end

endmodule : mux2_comb

// File: rtl/mux2_sel_reg.sv
// 2:1 selector with a registered output copy and a Select-transition counter.
// Optional even parity of Y_q is enabled by defining MUX2_PARITY_EN.
module mux2_sel_reg
    import mux2_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SEL_CNT_W = DEF_SEL_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Select,
    input  logic [WIDTH-1:0]     A_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic [WIDTH-1:0]     Y,
    output logic [WIDTH-1:0]     Y_q,
    output logic [SEL_CNT_W-1:0] sel_cnt
`ifdef MUX2_PARITY_EN
    ,
    output logic                 Y_par
`endif
);

    logic [WIDTH-1:0]     y_comb;
    logic [WIDTH-1:0]     y_q;
    logic [WIDTH-1:0]     y_d;
    logic                 sel_prev_q;
    logic                 sel_prev_d;
    logic [SEL_CNT_W-1:0] sel_cnt_q;
    logic [SEL_CNT_W-1:0] sel_cnt_d;

    mux2_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .sel_i(Select),
        .a_i  (A_in),
        .b_i  (B_in),
        .y_o  (y_comb)
    );

    // Counter wraps naturally from all-ones to zero.
    always_comb begin
        y_d        = y_comb;
        sel_prev_d = Select;
        sel_cnt_d  = sel_cnt_q;
        if (Select != sel_prev_q) begin
            sel_cnt_d = sel_cnt_q + SEL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q        <= '0;
            sel_prev_q <= SEL_A;
            sel_cnt_q  <= '0;
        end else begin
            y_q        <= y_d;
            sel_prev_q <= sel_prev_d;
            sel_cnt_q  <= sel_cnt_d;
        end
    end

`ifdef MUX2_PARITY_EN
    logic par_q;
    logic par_d;

    // Parity is taken from the value being captured so it always matches Y_q.
    always_comb begin
        par_d = ^y_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign Y_par = par_q;
`endif

    assign Y       = y_comb;
    assign Y_q     = y_q;
    assign sel_cnt = sel_cnt_q;

endmodule : mux2_sel_reg

// File: tb/tb_mux2_sel_reg.sv
// Directed self-checking bench for mux2_sel_reg (three instances of different sizes).
module tb_mux2_sel_reg;

    logic clk;
    logic rst;

    // WIDTH=1 instance: combinational truth-table sweep
    logic       sel1;
    logic       a1;
    logic       b1;
    logic       y1;
    logic       yq1;
    logic [7:0] cnt1;

    // WIDTH=8 instance: latency, counter, reset, hold, parity
    logic       sel8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] y8;
    logic [7:0] yq8;
    logic [7:0] cnt8;

    // WIDTH=8, SEL_CNT_W=2 instance: counter wrap
    logic       selc;
    logic [7:0] ac;
    logic [7:0] bc;
    logic [7:0] yc;
    logic [7:0] yqc;
    logic [1:0] cntc;

`ifdef MUX2_PARITY_EN
    logic par1;
    logic par8;
    logic parc;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    mux2_sel_reg #(.WIDTH(1), .SEL_CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .Select(sel1), .A_in(a1), .B_in(b1),
        .Y(y1), .Y_q(yq1), .sel_cnt(cnt1)
`ifdef MUX2_PARITY_EN
        , .Y_par(par1)
`endif
    );

    mux2_sel_reg #(.WIDTH(8), .SEL_CNT_W(8)) u_w8 (
        .clk(clk), .rst(rst), .Select(sel8), .A_in(a8), .B_in(b8),
        .Y(y8), .Y_q(yq8), .sel_cnt(cnt8)
`ifdef MUX2_PARITY_EN
        , .Y_par(par8)
`endif
    );

    mux2_sel_reg #(.WIDTH(8), .SEL_CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .Select(selc), .A_in(ac), .B_in(bc),
        .Y(yc), .Y_q(yqc), .sel_cnt(cntc)
`ifdef MUX2_PARITY_EN
        , .Y_par(parc)
`endif
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    logic [7:0] w1_tab;
    logic [7:0] exp_v;
    logic [1:0] cntc_tab[10];

    initial begin
        w1_tab = 8'b1010_1100;
        cntc_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};

        rst  = 1'b1;
        sel1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        sel8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
        selc = 1'b0; ac = 8'h00; bc = 8'hFF;

        // Reset state
        #2;
        check("rst_yq8", yq8, 32'h0);
        check("rst_cnt8", cnt8, 32'h0);
        check("rst_cntc", cntc, 32'h0);
        check("rst_yq1", yq1, 32'h0);
        check("rst_y8_follows_a", y8, 32'h5A);
`ifdef MUX2_PARITY_EN
        check("rst_par8", par8, 32'h0);
`endif
        step();
        check("rst_held_yq8", yq8, 32'h0);
        rst = 1'b0;
        step();

        // 1. Exhaustive WIDTH=1 sweep, 5 ns apart, 12 repetitions
        for (int rep = 0; rep < 12; rep++) begin
            for (int v = 0; v < 8; v++) begin
                sel1 = v[2];
                a1   = v[1];
                b1   = v[0];
                #1;
                check("sweep_y1", y1, {31'd0, w1_tab[v]});
                #4;
            end
        end
        step();

        // 2. Latency: Y_q is the previous cycle's Y
        do_reset();
        a8 = 8'h5A;
        b8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            sel8 = i[0];
            exp_v = (i[0] == 1'b0) ? 8'h5A : 8'hA5;
            #1;
            check("lat_y", y8, exp_v);
            exp_q.push_back(exp_v);
            step();
            check("lat_yq", yq8, exp_q.pop_front());
        end

        // 3. Counter: 10 toggles on 8-bit counter, 5 toggles on 2-bit counter
        sel8 = 1'b0;
        selc = 1'b0;
        do_reset();
        step();
        check("cnt_start8", cnt8, 32'h0);
        check("cnt_startc", cntc, 32'h0);
        for (int i = 0; i < 10; i++) begin
            sel8 = ~sel8;
            if (i < 5) selc = ~selc;
            step();
            check("cnt8", cnt8, i + 1);
            check("cntc_wrap", cntc, {30'd0, cntc_tab[i]});
        end

        // 4. Async reset between edges with Y_q=A5, sel_cnt=3
        sel8 = 1'b0;
        a8 = 8'h5A;
        b8 = 8'hA5;
        do_reset();
        step();
        sel8 = 1'b1; step();
        sel8 = 1'b0; step();
        sel8 = 1'b1; step();
        check("pre_rst_yq", yq8, 32'hA5);
        check("pre_rst_cnt", cnt8, 32'h3);
        #2 rst = 1'b1;
        #1;
        check("async_yq", yq8, 32'h0);
        check("async_cnt", cnt8, 32'h0);
        check("async_y", y8, 32'hA5);
        b8 = 8'h3C;
        #1;
        check("async_y_follow", y8, 32'h3C);
        rst = 1'b0;
        step();
        check("post_rst_cnt", cnt8, 32'h1);
        check("post_rst_yq", yq8, 32'h3C);

        // 6. Hold: Select stays 1 while B_in varies
        for (int i = 0; i < 20; i++) begin
            exp_v = 8'(i * 37 + 11);
            b8 = exp_v;
            #1;
            check("hold_y", y8, exp_v);
            exp_q.push_back(exp_v);
            step();
            check("hold_yq", yq8, exp_q.pop_front());
        end
        check("hold_cnt", cnt8, 32'h1);

`ifdef MUX2_PARITY_EN
        // 5. Parity of Y_q
        sel8 = 1'b0;
        a8 = 8'h07;
        step();
        check("par_yq07", yq8, 32'h07);
        check("par_07", par8, 32'h1);
        a8 = 8'h03;
        step();
        check("par_yq03", yq8, 32'h03);
        check("par_03", par8, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mux2_sel_reg
